// File: rtl/forth_printer.sv
// -----------------------------------------------------------------------------
// forth_printer
// Output end of the CPU result path. Takes one result per request from the
// stack CPU and renders it as a stream of ASCII bytes for the UART transmitter:
//   value  -> signed decimal followed by a space, e.g. "-42 "
//   error  -> "?<code>\r\n"
// The value is converted by a bit-serial restoring divide by ten (DATA cycles
// per digit); digits come out least significant first and are stacked in a
// small LIFO, then popped most significant first.
//
// Ports
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_en           clock enable; 0 freezes every register
//   i_valid        request strobe, taken only while o_ready=1
//   i_value        request carries a value in i_data
//   i_data         value to print (two's complement when SIGNED=1)
//   i_err          CPU error code, 0 = OK; a nonzero code wins over i_value
//   o_ready        1 while idle
//   o_drop         one-cycle pulse after a request arrived while busy
//   o_tx_byte      ASCII byte, registered, stable while stalled
//   o_tx_valid     o_tx_byte valid, registered
//   i_tx_ready     transmitter takes the byte on an edge with o_tx_valid=1
// -----------------------------------------------------------------------------
module forth_printer #(
    parameter int DATA   = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic            i_value,
    input  logic [DATA-1:0] i_data,
    input  logic [2:0]      i_err,
    output logic            o_ready,
    output logic            o_drop,
    output logic [7:0]      o_tx_byte,
    output logic            o_tx_valid,
    input  logic            i_tx_ready
);

    localparam int CW = (DATA > 1) ? $clog2(DATA) : 1;
    localparam int DW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SIGN,
        S_DIG,
        S_SPC,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [DATA-1:0] dvd;        // dividend; quotient bits shift in from the right
    logic [3:0]      rem;        // partial remainder, always < 10
    logic [CW-1:0]   cnt;        // quotient bit index within the current digit
    logic [DW-1:0]   depth;      // digits held in the LIFO
    logic            neg;
    logic [2:0]      err_code;
    logic [1:0]      err_idx;    // position within "?<code>\r\n"
    logic [3:0]      dig_buf [DIGITS];

    logic [4:0]      trial;
    logic            qbit;
    logic [3:0]      rem_step;
    logic [DATA-1:0] quo_nxt;
    logic            last_bit;
    logic            hs;
    logic            dig_pop;
    logic [DW-1:0]   pop_idx;
    logic [1:0]      err_idx_nxt;
    logic            neg_in;
    logic [DATA-1:0] mag_in;
    logic [7:0]      tx_byte_nxt;
    logic            tx_valid_nxt;

    function automatic logic is_byte_state(input state_t s);
        return s inside {S_SIGN, S_DIG, S_SPC, S_ERR};
    endfunction

    // One restoring-divide step: bring in the next dividend bit, subtract ten
    // when it fits. The remainder stays below 20, so 4-bit wraparound
    // subtraction yields the exact result.
    assign trial    = {rem, dvd[DATA-1]};
    assign qbit     = (trial >= 5'd10);
    assign rem_step = qbit ? (trial[3:0] - 4'd10) : trial[3:0];
    assign quo_nxt  = {dvd[DATA-2:0], qbit};
    assign last_bit = (cnt == CW'(DATA - 1));

    assign hs          = o_tx_valid & i_tx_ready;
    assign dig_pop     = (state == S_DIG) & hs;
    // Byte to show next: the top digit, or the one beneath it when the top is
    // being handed over on this edge.
    assign pop_idx     = depth - DW'(1) - DW'(dig_pop);
    assign err_idx_nxt = ((state == S_ERR) && hs) ? err_idx + 2'd1 : err_idx;

    // Magnitude in DATA bits unsigned, so the most negative value still fits.
    assign neg_in = (SIGNED != 0) && i_data[DATA-1];
    assign mag_in = neg_in ? (~i_data + DATA'(1)) : i_data;

    assign o_ready = (state == S_IDLE);

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else if (i_en) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (i_en) begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (i_err != 3'd0) begin
                            state_nxt = S_ERR;
                        end else if (i_value) begin
                            state_nxt = S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    if (last_bit && (quo_nxt == '0)) begin
                        state_nxt = neg ? S_SIGN : S_DIG;
                    end
                end
                S_SIGN:  if (hs) state_nxt = S_DIG;
                S_DIG:   if (hs && (depth == DW'(1))) state_nxt = S_SPC;
                S_SPC:   if (hs) state_nxt = S_IDLE;
                S_ERR:   if (hs && (err_idx == 2'd3)) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic. The first cycle in a byte state is silent while the byte
    // register loads; after that, bytes follow each other with no gap.
    always_comb begin
        tx_valid_nxt = 1'b0;
        tx_byte_nxt  = 8'h00;
        if (is_byte_state(state) && is_byte_state(state_nxt)) begin
            tx_valid_nxt = 1'b1;
            case (state_nxt)
                S_SIGN: tx_byte_nxt = 8'h2D;
                S_DIG:  tx_byte_nxt = 8'h30 + {4'h0, dig_buf[pop_idx]};
                S_SPC:  tx_byte_nxt = 8'h20;
                S_ERR: begin
                    case (err_idx_nxt)
                        2'd0:    tx_byte_nxt = 8'h3F;
                        2'd1:    tx_byte_nxt = 8'h30 + {5'h00, err_code};
                        2'd2:    tx_byte_nxt = 8'h0D;
                        default: tx_byte_nxt = 8'h0A;
                    endcase
                end
                default: tx_byte_nxt = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tx_valid <= 1'b0;
            o_tx_byte  <= 8'h00;
            o_drop     <= 1'b0;
        end else if (i_en) begin
            o_tx_valid <= tx_valid_nxt;
            o_tx_byte  <= tx_byte_nxt;
            o_drop     <= i_valid & (state != S_IDLE);
        end
    end

    // Datapath. Accepting any request loads every field; only the ones the
    // chosen path reads matter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dvd      <= '0;
            rem      <= '0;
            cnt      <= '0;
            depth    <= '0;
            neg      <= 1'b0;
            err_code <= '0;
            err_idx  <= '0;
        end else if (i_en) begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        dvd      <= mag_in;
                        neg      <= neg_in;
                        rem      <= '0;
                        cnt      <= '0;
                        depth    <= '0;
                        err_code <= i_err;
                        err_idx  <= '0;
                    end
                end
                S_CONV: begin
                    dvd <= quo_nxt;
                    if (last_bit) begin
                        depth <= depth + DW'(1);
                        rem   <= '0;
                        cnt   <= '0;
                    end else begin
                        rem <= rem_step;
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DIG:   if (hs) depth <= depth - DW'(1);
                S_ERR:   err_idx <= err_idx_nxt;
                default: ;
            endcase
        end
    end

    // Digit LIFO storage.
    // NOTE: the array itself is not reset; depth (reset to 0) marks which
    // entries are meaningful, so stale contents are never read.
    always_ff @(posedge i_clk) begin
        if (i_en && (state == S_CONV) && last_bit) begin
            dig_buf[depth] <= rem_step;
        end
    end

endmodule

// File: tb/tb_forth_printer.sv
// -----------------------------------------------------------------------------
// tb_forth_printer
// Self-checking bench for forth_printer. Every accepted request appends the
// text it must produce (built with $sformatf from the request) to a byte
// queue; a monitor compares every valid output byte against the queue head,
// which also proves the byte stays put while stalled. Directed cases pin
// exact strings and latencies; a random phase mixes values, errors, stalls
// and clock-enable gaps.
// -----------------------------------------------------------------------------
module tb_forth_printer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_value = 1'b0;
    logic [31:0] i_data = '0;
    logic [2:0]  i_err = '0;
    logic        o_ready;
    logic        o_drop;
    logic [7:0]  o_tx_byte;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;

    int          tests = 0;
    int          fails = 0;

    logic [7:0]  exp_q[$];
    string       rx = "";
    logic        prev_hold = 1'b0;

    int          ready_mode = 0;  // 0 always ready, 1 random, 2 20 stalled valid cycles then random, 3 never
    int          en_mode = 0;     // 0 always enabled, 1 random gaps
    int          low_cnt = 0;

    forth_printer #(.DATA(32), .DIGITS(10), .SIGNED(1)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_value    (i_value),
        .i_data     (i_data),
        .i_err      (i_err),
        .o_ready    (o_ready),
        .o_drop     (o_drop),
        .o_tx_byte  (o_tx_byte),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic string hexs(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
        return r;
    endfunction

    task automatic check_str(input string name, input string got, input string want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got [%s], expected [%s]", name, hexs(got), hexs(want));
        end
    endtask

    // Reference: the exact text a request must produce.
    function automatic string model(input logic [31:0] d, input bit v, input logic [2:0] e);
        if (e != 3'd0) return $sformatf("?%0d\r\n", e);
        if (v) return $sformatf("%0d ", $signed(d));
        return "";
    endfunction

    // Transmitter side: ready and clock-enable change just after each edge.
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0: i_tx_ready = 1'b1;
            1: i_tx_ready = 1'($urandom_range(0, 1));
            2: begin
                if (low_cnt < 20 && o_tx_valid) begin
                    i_tx_ready = 1'b0;
                    low_cnt++;
                end else begin
                    i_tx_ready = 1'($urandom_range(0, 1));
                end
            end
            default: i_tx_ready = 1'b0;
        endcase
        if (ready_mode != 2) low_cnt = 0;
        i_en = (en_mode != 0) ? ($urandom_range(0, 6) != 0) : 1'b1;
    end

    // Monitor: every valid byte must equal the next expected byte.
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_hold = 1'b0;
            exp_q.delete();
        end else begin
            if (prev_hold) check("tx_valid_held", 64'(o_tx_valid), 64'd1);
            if (o_ready) check("idle_valid_low", 64'(o_tx_valid), 64'd0);
            if (o_tx_valid) begin
                if (exp_q.size() == 0) begin
                    check("tx_unexpected_byte", 64'(o_tx_byte), 64'hFFFF);
                end else begin
                    check("tx_byte", 64'(o_tx_byte), 64'(exp_q[0]));
                    if (i_tx_ready && i_en) begin
                        void'(exp_q.pop_front());
                        rx = $sformatf("%s%c", rx, o_tx_byte);
                    end
                end
            end
            prev_hold = o_tx_valid && !(i_tx_ready && i_en);
        end
    end

    task automatic send(input logic [31:0] d, input bit v, input logic [2:0] e);
        int    t = 0;
        string s;
        @(negedge i_clk);
        while (!(o_ready && i_en)) begin
            @(negedge i_clk);
            t++;
            if (t > 5000) begin
                check("send_timeout", 64'd0, 64'd1);
                return;
            end
        end
        i_valid = 1'b1;
        i_data  = d;
        i_value = v;
        i_err   = e;
        s = model(d, v, e);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        @(negedge i_clk);
        while (!(o_ready && exp_q.size() == 0)) begin
            @(negedge i_clk);
            t++;
            if (t > 5000) begin
                check({name, "_timeout"}, 64'd0, 64'd1);
                return;
            end
        end
    endtask

    task automatic print_and_check(input string name, input logic [31:0] d, input bit v,
                                   input logic [2:0] e, input string want);
        int start = rx.len();
        send(d, v, e);
        wait_done(name);
        check_str(name, rx.substr(start, rx.len() - 1), want);
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic reset_now(input string name);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        check({name, "_valid"}, 64'(o_tx_valid), 64'd0);
        check({name, "_ready"}, 64'(o_ready), 64'd1);
        check({name, "_byte"}, 64'(o_tx_byte), 64'd0);
        @(negedge i_clk);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          j;
        int          start;
        int          kind;
        logic [31:0] d;
        logic [2:0]  e;
        bit          v;

        #1;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_tx_valid), 64'd0);
        check("rst_byte", 64'(o_tx_byte), 64'd0);
        check("rst_drop", 64'(o_drop), 64'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst = 1'b0;

        // 1234: latency 4*32+1 edges, then o_ready one cycle after the space.
        start = rx.len();
        send(32'd1234, 1'b1, 3'd0);
        j = 0;
        @(negedge i_clk);
        while (!o_tx_valid && j < 2000) begin
            @(negedge i_clk);
            j++;
        end
        check("lat_1234", 64'(j), 64'd129);
        repeat (4) @(negedge i_clk);
        check("last_byte_space", 64'(o_tx_byte), 64'h20);
        check("ready_low_at_space", 64'(o_ready), 64'd0);
        @(negedge i_clk);
        check("ready_after_space", 64'(o_ready), 64'd1);
        check_str("str_1234", rx.substr(start, rx.len() - 1), "1234 ");

        print_and_check("str_0", 32'd0, 1'b1, 3'd0, "0 ");
        print_and_check("str_m1", 32'hFFFF_FFFF, 1'b1, 3'd0, "-1 ");
        print_and_check("str_min", 32'h8000_0000, 1'b1, 3'd0, "-2147483648 ");
        print_and_check("str_max", 32'h7FFF_FFFF, 1'b1, 3'd0, "2147483647 ");

        // Error wins over a value; first byte one edge after accept.
        start = rx.len();
        send(32'd99, 1'b1, 3'd2);
        j = 0;
        @(negedge i_clk);
        while (!o_tx_valid && j < 2000) begin
            @(negedge i_clk);
            j++;
        end
        check("lat_err", 64'(j), 64'd1);
        wait_done("err2");
        check_str("str_err2", rx.substr(start, rx.len() - 1), "?2\r\n");

        // Stalled transmitter, with a 20-cycle hold.
        ready_mode = 2;
        print_and_check("str_57_stall", 32'd57, 1'b1, 3'd0, "57 ");
        ready_mode = 0;

        // Request during conversion is dropped.
        start = rx.len();
        send(32'd9876, 1'b1, 3'd0);
        repeat (5) @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = 32'd5;
        i_value = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        check("drop_pulse", 64'(o_drop), 64'd1);
        @(negedge i_clk);
        check("drop_one_cycle", 64'(o_drop), 64'd0);
        wait_done("drop");
        check_str("str_drop", rx.substr(start, rx.len() - 1), "9876 ");

        // No value, no error: consumed silently.
        start = rx.len();
        send(32'd77, 1'b0, 3'd0);
        repeat (3) begin
            @(negedge i_clk);
            check("novalue_ready", 64'(o_ready), 64'd1);
        end
        check_str("str_novalue", rx.substr(start, rx.len() - 1), "");

        // Back-to-back requests.
        start = rx.len();
        send(32'd3, 1'b1, 3'd0);
        send(32'hFFFF_FFF9, 1'b1, 3'd0);
        send(32'd0, 1'b1, 3'd7);
        wait_done("b2b");
        check_str("str_b2b", rx.substr(start, rx.len() - 1), "3 -7 ?7\r\n");

        // Reset mid-conversion, then mid-digit output.
        send(32'd123456, 1'b1, 3'd0);
        repeat (40) @(negedge i_clk);
        reset_now("rst_conv");
        print_and_check("str_after_rst_conv", 32'd8, 1'b1, 3'd0, "8 ");
        ready_mode = 3;
        send(32'd42, 1'b1, 3'd0);
        j = 0;
        while (!o_tx_valid && j < 2000) begin
            @(negedge i_clk);
            j++;
        end
        check("dig_reached", 64'(o_tx_valid), 64'd1);
        reset_now("rst_dig");
        ready_mode = 0;
        print_and_check("str_after_rst_dig", 32'd7, 1'b1, 3'd0, "7 ");

        // Random traffic with random stalls and enable gaps.
        ready_mode = 1;
        en_mode = 1;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            e = 3'd0;
            v = ($urandom_range(0, 7) != 0);
            case (kind)
                0: d = $urandom_range(0, 99);
                1: d = $urandom;
                2: d = -$urandom_range(1, 1000);
                3: begin
                    case ($urandom_range(0, 3))
                        0: d = 32'h8000_0000;
                        1: d = 32'h7FFF_FFFF;
                        2: d = 32'hFFFF_FFFF;
                        default: d = 32'd0;
                    endcase
                end
                default: begin
                    d = $urandom;
                    e = 3'($urandom_range(1, 7));
                end
            endcase
            send(d, v, e);
        end
        wait_done("random");
        check("random_drained", 64'(exp_q.size()), 64'd0);
        en_mode = 0;
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
